// File: rtl/serial_word_deser.sv
// Serial-to-parallel receiver: collects framed serial bits (MSB- or LSB-first)
// into N-bit words and presents them on a one-entry valid/ready holding register.
module serial_word_deser #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         sin_valid,
    input  logic         sin_data,
    input  logic         sin_frame,
    input  logic         dir,
    input  logic         word_ready,
    input  logic         clr_ovf,
    output logic         word_valid,
    output logic [N-1:0] word_data,
    output logic         busy,
    output logic         frame_err,
    output logic         overflow
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t         state, state_nx;
    logic [N-1:0]   sr, sr_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic           dir_q, dir_nx;
    logic           word_valid_nx;
    logic [N-1:0]   word_data_nx;
    logic           frame_err_nx;
    logic           overflow_nx;
    logic           start;
    logic           accept;
    logic           eff_dir;
    logic           complete;
    logic [N-1:0]   base;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            sr         <= '0;
            cnt        <= '0;
            dir_q      <= 1'b0;
            word_valid <= 1'b0;
            word_data  <= '0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nx;
            sr         <= sr_nx;
            cnt        <= cnt_nx;
            dir_q      <= dir_nx;
            word_valid <= word_valid_nx;
            word_data  <= word_data_nx;
            frame_err  <= frame_err_nx;
            overflow   <= overflow_nx;
        end
    end

    // A frame-start bit always begins a fresh word from an empty shift register,
    // using the incoming dir; continuation bits use the dir latched at frame start.
    always_comb begin
        state_nx      = state;
        sr_nx         = sr;
        cnt_nx        = cnt;
        dir_nx        = dir_q;
        word_valid_nx = word_valid;
        word_data_nx  = word_data;
        complete      = 1'b0;

        start   = sin_valid & sin_frame;
        accept  = sin_valid & (sin_frame | (state == SHIFT));
        eff_dir = start ? dir : dir_q;
        base    = start ? '0 : sr;

        frame_err_nx = sin_valid & (sin_frame == (state == SHIFT));

        if (accept) begin
            sr_nx  = eff_dir ? {sin_data, base[N-1:1]} : {base[N-2:0], sin_data};
            cnt_nx = start ? CW'(1) : cnt + CW'(1);
            dir_nx = eff_dir;
            if (cnt_nx == CW'(N)) begin
                complete = 1'b1;
                cnt_nx   = '0;
                state_nx = IDLE;
            end else begin
                state_nx = SHIFT;
            end
        end

        // Set beats clear when both land on the same edge.
        overflow_nx = overflow & ~clr_ovf;
        if (complete) begin
            if (!word_valid || word_ready) begin
                word_valid_nx = 1'b1;
                word_data_nx  = sr_nx;
            end else begin
                overflow_nx = 1'b1;
            end
        end else if (word_valid && word_ready) begin
            word_valid_nx = 1'b0;
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_serial_word_deser.sv
// Self-checking bench for serial_word_deser: directed scenarios plus random
// traffic, scored against a bit-queue reference model of the receiver.
module tb_serial_word_deser;

    localparam int N = 4;

    logic         clk;
    logic         reset_n;
    logic         sin_valid;
    logic         sin_data;
    logic         sin_frame;
    logic         dir;
    logic         word_ready;
    logic         clr_ovf;
    logic         word_valid;
    logic [N-1:0] word_data;
    logic         busy;
    logic         frame_err;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    // Reference model state: bits of the frame in progress, held words, flags.
    logic         cur[$];
    logic         cur_dir;
    logic         in_frame;
    logic [N-1:0] exp_q[$];
    logic         exp_ovf;
    logic         exp_ferr;
    logic         held;
    logic         done;
    logic [N-1:0] w;

    serial_word_deser #(.N(N)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sin_valid  (sin_valid),
        .sin_data   (sin_data),
        .sin_frame  (sin_frame),
        .dir        (dir),
        .word_ready (word_ready),
        .clr_ovf    (clr_ovf),
        .word_valid (word_valid),
        .word_data  (word_data),
        .busy       (busy),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic d, input logic f,
                                 input logic dr, input logic rdy, input logic clr);
        @(negedge clk);
        sin_valid  = v;
        sin_data   = d;
        sin_frame  = f;
        dir        = dr;
        word_ready = rdy;
        clr_ovf    = clr;
    endtask

    task automatic send_word(input logic [N-1:0] val, input logic dr, input int gap,
                             input logic rdy, input logic rdy_last);
        for (int i = 0; i < N; i++) begin
            applyStimulus(1'b1, dr ? val[i] : val[N-1-i], i == 0, dr,
                          (i == N-1) ? rdy_last : rdy, 1'b0);
            if (i < N-1)
                repeat (gap) applyStimulus(1'b0, 1'b0, 1'b0, dr, rdy, 1'b0);
        end
    endtask

    task automatic idle(input logic rdy);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    // Model: a word is the ordered list of accepted bits, placed by bit order.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur.delete();
            exp_q.delete();
            in_frame = 1'b0;
            cur_dir  = 1'b0;
            exp_ovf  = 1'b0;
            exp_ferr = 1'b0;
        end else begin
            held     = (exp_q.size() != 0);
            done     = 1'b0;
            exp_ferr = 1'b0;
            w        = '0;
            if (sin_valid) begin
                if (sin_frame) begin
                    exp_ferr = in_frame;
                    cur.delete();
                    cur.push_back(sin_data);
                    cur_dir  = dir;
                    in_frame = 1'b1;
                end else if (!in_frame) begin
                    exp_ferr = 1'b1;
                end else begin
                    cur.push_back(sin_data);
                end
                if (cur.size() == N) begin
                    for (int i = 0; i < N; i++) begin
                        if (cur_dir) w[i] = cur[i];
                        else         w[N-1-i] = cur[i];
                    end
                    done     = 1'b1;
                    in_frame = 1'b0;
                    cur.delete();
                end
            end
            if (clr_ovf) exp_ovf = 1'b0;
            if (held && word_ready) void'(exp_q.pop_front());
            if (done) begin
                if (held && !word_ready) exp_ovf = 1'b1;
                else                     exp_q.push_back(w);
            end
        end
    end

    // Monitor: compares every presented output against the scoreboard head.
    always @(negedge clk) begin
        checkOutput("mon_word_valid", {31'b0, word_valid}, {31'b0, exp_q.size() != 0});
        if (word_valid && exp_q.size() != 0)
            checkOutput("mon_word_data", 32'(word_data), 32'(exp_q[0]));
        checkOutput("mon_busy", {31'b0, busy}, {31'b0, in_frame});
        checkOutput("mon_frame_err", {31'b0, frame_err}, {31'b0, exp_ferr});
        checkOutput("mon_overflow", {31'b0, overflow}, {31'b0, exp_ovf});
    end

    initial begin
        reset_n    = 1'b0;
        sin_valid  = 1'b0;
        sin_data   = 1'b0;
        sin_frame  = 1'b0;
        dir        = 1'b0;
        word_ready = 1'b0;
        clr_ovf    = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_valid", {31'b0, word_valid}, 32'd0);
        checkOutput("reset_data", 32'(word_data), 32'd0);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        reset_n = 1'b1;

        // MSB-first word, held then consumed
        send_word(4'hB, 1'b0, 0, 1'b0, 1'b0);
        idle(1'b0);
        checkOutput("t1_valid", {31'b0, word_valid}, 32'd1);
        checkOutput("t1_data", 32'(word_data), 32'hB);
        checkOutput("t1_ferr", {31'b0, frame_err}, 32'd0);
        idle(1'b1);
        idle(1'b0);
        checkOutput("t1_consumed", {31'b0, word_valid}, 32'd0);

        // LSB-first with dir flipped mid-frame
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        checkOutput("t2_data", 32'(word_data), 32'hD);
        idle(1'b1);
        idle(1'b0);

        // Gapped bits, ready held high: valid for exactly one cycle
        send_word(4'h6, 1'b0, 2, 1'b1, 1'b1);
        idle(1'b1);
        checkOutput("t3_valid", {31'b0, word_valid}, 32'd1);
        checkOutput("t3_data", 32'(word_data), 32'h6);
        idle(1'b0);
        checkOutput("t3_valid_drop", {31'b0, word_valid}, 32'd0);

        // Overflow, clear, then replace-on-consume
        send_word(4'hA, 1'b0, 0, 1'b0, 1'b0);
        idle(1'b0);
        send_word(4'h5, 1'b0, 0, 1'b0, 1'b0);
        idle(1'b0);
        checkOutput("t4_ovf_set", {31'b0, overflow}, 32'd1);
        checkOutput("t4_held", 32'(word_data), 32'hA);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        checkOutput("t4_ovf_clr", {31'b0, overflow}, 32'd0);
        send_word(4'h3, 1'b0, 0, 1'b0, 1'b1);
        idle(1'b0);
        checkOutput("t4_replace_data", 32'(word_data), 32'h3);
        checkOutput("t4_replace_valid", {31'b0, word_valid}, 32'd1);
        idle(1'b1);
        idle(1'b0);

        // Restart mid-frame, then stray bit in IDLE
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t5_ferr_pulse", {31'b0, frame_err}, 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t5_ferr_once", {31'b0, frame_err}, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        checkOutput("t5_data", 32'(word_data), 32'h3);
        idle(1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        checkOutput("t5_stray_ferr", {31'b0, frame_err}, 32'd1);
        checkOutput("t5_stray_busy", {31'b0, busy}, 32'd0);
        idle(1'b0);
        checkOutput("t5_stray_noword", {31'b0, word_valid}, 32'd0);

        // Asynchronous reset mid-frame with a word held
        send_word(4'h9, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #3 reset_n = 1'b0;
        #1;
        checkOutput("t6_rst_valid", {31'b0, word_valid}, 32'd0);
        checkOutput("t6_rst_data", 32'(word_data), 32'd0);
        checkOutput("t6_rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("t6_rst_ovf", {31'b0, overflow}, 32'd0);
        checkOutput("t6_rst_ferr", {31'b0, frame_err}, 32'd0);
        idle(1'b0);
        reset_n = 1'b1;
        send_word(4'hE, 1'b0, 0, 1'b0, 1'b0);
        idle(1'b0);
        checkOutput("t6_after_data", 32'(word_data), 32'hE);
        idle(1'b1);

        // Random traffic: mostly well-formed frames with occasional errors
        for (int c = 0; c < 600; c++) begin
            logic v;
            logic f;
            v = ($urandom_range(0, 9) < 7);
            f = in_frame ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 19) != 0);
            applyStimulus(v, 1'($urandom), f, 1'($urandom),
                          1'($urandom), $urandom_range(0, 19) == 0);
        end
        repeat (4) idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
